// File: rtl/skinny_round_ctrl.sv
// ---------------------------------------------------------------------------
// skinny_round_ctrl
//   Round sequencer for the SKINNY-128-384+ core used by Romulus-N. Drives
//   the select/enable of the (unreset) 6-bit round-constant LFSR. It turns
//   the LFSR's rounded constant into the AddConstants nibbles c0/c1/c2. It
//   also emits per-round strobes and a valid/ready result handshake.
//
//   Optional feature macro: ROUND_CTRL_ABORT_EN adds a synchronous `abort`
//   input that returns ROUND/DONE to IDLE.
//
//   Ports:
//     clk, rst_n         clock (rising edge), async active-low reset
//     start / ready      block request, taken when start & ready
//     lfsr_sel, lfsr_en  to LFSR: sel=1 loads zero, en=1 updates register
//     rc_in[5:0]         rounded constant from LFSR (combinational)
//     round_act          a round executes this cycle
//     round_idx          0-based round index (0 when idle)
//     first_round        round_act & round_idx == 0
//     last_round         round_act & round_idx == NROUNDS-1
//     rc_c0/c1/c2[3:0]   AddConstants nibbles, 0 when not in a round
//     out_valid/out_ready  result handshake
//     dbg_state[1:0]     current FSM state (FLUSH=0 IDLE=1 ROUND=2 DONE=3)
//     abort              (ROUND_CTRL_ABORT_EN only) drop the current block
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. start is taken only in IDLE. It is never queued. out_valid
//   stays high and stable until out_ready is seen.
// ---------------------------------------------------------------------------
module skinny_round_ctrl #(
  parameter int NROUNDS = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ROUND_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             lfsr_sel,
  output logic             lfsr_en,
  input  logic [5:0]       rc_in,
  output logic             round_act,
  output logic [CNT_W-1:0] round_idx,
  output logic             first_round,
  output logic             last_round,
  output logic [3:0]       rc_c0,
  output logic [3:0]       rc_c1,
  output logic [3:0]       rc_c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  if (NROUNDS < 2 || NROUNDS > 63 || (2 ** CNT_W) <= NROUNDS) begin : g_bad_cfg
    $error("skinny_round_ctrl: NROUNDS must be 2..63 and below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_IDLE  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NROUNDS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_abort;
  logic             w_round;

`ifdef ROUND_CTRL_ABORT_EN
  // abort only matters while a block is in flight.
  assign w_abort = abort & ((r_state == S_ROUND) | (r_state == S_DONE));
`else
  assign w_abort = 1'b0;
`endif

  assign w_round = (r_state == S_ROUND);

  // abort outranks both the round transition and the out_ready handshake.
  // The counter only advances up to LAST_IDX, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FLUSH;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_FLUSH: r_state <= S_IDLE;
        S_IDLE: begin
          if (start) begin
            r_state <= S_ROUND;
            r_cnt   <= '0;
          end
        end
        S_ROUND: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_IDX) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (w_abort || out_ready) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_FLUSH;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are a pure decode of the state and counter registers. The LFSR
  // has no reset of its own. It is therefore held at zero in every state
  // except ROUND. FLUSH and IDLE both clear it, so round 0 always sees 0x01.
  // lfsr_sel/lfsr_en are gated by rst_n so every output reads 0 during reset.
  assign lfsr_en     = rst_n;
  assign lfsr_sel    = rst_n & (~w_round | w_abort);
  assign ready       = (r_state == S_IDLE);
  assign round_act   = w_round;
  assign round_idx   = w_round ? r_cnt : '0;
  assign first_round = w_round & (r_cnt == '0);
  assign last_round  = w_round & (r_cnt == LAST_IDX);
  assign rc_c0       = w_round ? rc_in[3:0] : 4'h0;
  assign rc_c1       = w_round ? {2'b00, rc_in[5:4]} : 4'h0;
  assign rc_c2       = w_round ? 4'h2 : 4'h0;
  assign out_valid   = (r_state == S_DONE) & ~w_abort;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
module tb_skinny_round_ctrl;

  localparam int NROUNDS = 40;
  localparam int CNT_W   = 6;

  // ---- clock / reset --------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start;
  logic             abort;
  logic             ready;
  logic             lfsr_sel;
  logic             lfsr_en;
  logic [5:0]       rc_in;
  logic             round_act;
  logic [CNT_W-1:0] round_idx;
  logic             first_round;
  logic             last_round;
  logic [3:0]       rc_c0;
  logic [3:0]       rc_c1;
  logic [3:0]       rc_c2;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       dbg_state;

  skinny_round_ctrl #(.NROUNDS(NROUNDS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef ROUND_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .ready       (ready),
    .lfsr_sel    (lfsr_sel),
    .lfsr_en     (lfsr_en),
    .rc_in       (rc_in),
    .round_act   (round_act),
    .round_idx   (round_idx),
    .first_round (first_round),
    .last_round  (last_round),
    .rc_c0       (rc_c0),
    .rc_c1       (rc_c1),
    .rc_c2       (rc_c2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state   (dbg_state)
  );

  // ---- LFSR model (no reset, powers up with junk) ----------------------------
  logic [5:0] lfsr_q;
  initial lfsr_q = 6'($urandom_range(63, 2));
  assign rc_in = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4] ^ 1'b1};
  always @(posedge clk) begin
    if (lfsr_en) lfsr_q <= lfsr_sel ? 6'h00 : rc_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard -------------------------------------------------------------
  logic [5:0] exp_q[$];
  logic [5:0] exp_rc [0:NROUNDS-1];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---- driver tasks -------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_block();
    check("ready_before_start", ready, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = {};
    for (int i = 0; i < NROUNDS; i++) exp_q.push_back(exp_rc[i]);
  endtask

  task automatic check_rounds(input int n);
    logic [5:0] e;
    for (int r = 0; r < n; r++) begin
      e = exp_q.pop_front();
      check("round_act", round_act, 1);
      check("round_idx", round_idx, r);
      check("first_round", first_round, (r == 0));
      check("last_round", last_round, (r == NROUNDS - 1));
      check("rc_c0", rc_c0, e[3:0]);
      check("rc_c1", rc_c1, {2'b00, e[5:4]});
      check("rc_c2", rc_c2, 4'h2);
      check("ready_in_round", ready, 0);
      check("sel_in_round", lfsr_sel, 0);
      check("out_valid_in_round", out_valid, 0);
      tick();
    end
  endtask

  // ---- stimulus -------------------------------------------------------------------
  initial begin
    int t_first[2];
    int n_found;
    logic [5:0] consts [0:NROUNDS-1] = '{
      6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
      6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
      6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
      6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};
    for (int i = 0; i < NROUNDS; i++) exp_rc[i] = consts[i];

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;

    // Reset: all outputs 0 while held
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_sel", lfsr_sel, 0);
    check("rst_en", lfsr_en, 0);
    check("rst_round_act", round_act, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rc_c2", rc_c2, 0);
    rst_n = 1'b1;
    #1;
    check("flush_state", dbg_state, 0);
    check("flush_ready", ready, 0);
    check("flush_sel", lfsr_sel, 1);
    check("flush_en", lfsr_en, 1);
    tick();
    check("idle_state", dbg_state, 1);
    check("idle_ready", ready, 1);
    check("idle_sel", lfsr_sel, 1);
    check("idle_en", lfsr_en, 1);
    check("idle_rc_c0", rc_c0, 0);

    // Single block, result taken immediately
    out_ready = 1'b1;
    start_block();
    check_rounds(NROUNDS);
    check("done_out_valid", out_valid, 1);
    check("done_ready", ready, 0);
    check("done_round_act", round_act, 0);
    check("done_sel", lfsr_sel, 1);
    tick();
    check("after_done_ready", ready, 1);
    check("after_done_out_valid", out_valid, 0);

    // Backpressure: held in DONE, start pulses ignored
    out_ready = 1'b0;
    start_block();
    check_rounds(NROUNDS);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      check("bp_out_valid", out_valid, 1);
      check("bp_ready", ready, 0);
      check("bp_state", dbg_state, 3);
      tick();
    end
    // start & out_ready together in DONE: start dropped, IDLE next
    start = 1'b1;
    out_ready = 1'b1;
    check("bp_release_valid", out_valid, 1);
    tick();
    start = 1'b0;
    check("bp_idle_state", dbg_state, 1);
    check("bp_idle_ready", ready, 1);
    check("bp_idle_round_act", round_act, 0);
    tick();

    // Mid-run reset at round 17
    start_block();
    check_rounds(17);
    rst_n = 1'b0;
    #1;
    check("mrst_round_act", round_act, 0);
    check("mrst_round_idx", round_idx, 0);
    check("mrst_rc_c0", rc_c0, 0);
    check("mrst_rc_c1", rc_c1, 0);
    check("mrst_rc_c2", rc_c2, 0);
    check("mrst_sel", lfsr_sel, 0);
    check("mrst_en", lfsr_en, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst_flush_ready", ready, 0);
    tick();
    start_block();
    check_rounds(NROUNDS);
    check("mrst_done_valid", out_valid, 1);
    tick();

    // Back-to-back: start held, out_ready tied high
    start = 1'b1;
    n_found = 0;
    for (int i = 0; i < 200 && n_found < 2; i++) begin
      tick();
      if (first_round) begin
        t_first[n_found] = cyc;
        n_found++;
      end
    end
    start = 1'b0;
    check("b2b_found_two", n_found, 2);
    if (n_found == 2) check("b2b_spacing", t_first[1] - t_first[0], NROUNDS + 2);
    for (int i = 0; i < 100 && !ready; i++) tick();
    check("b2b_back_idle", ready, 1);

`ifdef ROUND_CTRL_ABORT_EN
    // Abort at round 20
    out_ready = 1'b0;
    start_block();
    check_rounds(20);
    abort = 1'b1;
    #1;
    check("abort_sel", lfsr_sel, 1);
    check("abort_out_valid", out_valid, 0);
    tick();
    abort = 1'b0;
    check("abort_state", dbg_state, 1);
    check("abort_ready", ready, 1);
    check("abort_out_valid_after", out_valid, 0);
    start_block();
    check_rounds(NROUNDS);
    check("abort_done_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
`endif

    // ---- final report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
